// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory port bundle for the load/store controller.
// master = requester plus memory side (testbench/core); slave = lsu_mem_ctrl.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    logic              mem_we;
    logic [3:0]        mem_byteEnable;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_we, mem_byteEnable, mem_a, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_we, mem_byteEnable, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: decodes funct3, drives the byte-enable write port,
// waits out the synchronous read latency and returns extended load data.
//
// state   | meaning
// IDLE    | ready for a request; illegal requests go straight to RESP
// WRITE   | single cycle with mem_we and lane enables asserted
// READ    | address held while the read latency counter runs down
// RESP    | one-cycle resp_valid pulse with err/rdata
module lsu_mem_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       mem_wd_q, mem_wd_d;

    // Address bits above the memory window wrap and are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad_f3;
        logic misaligned;
        if (we) begin
            bad_f3 = f3[2] | (f3[1:0] == 2'b11);
        end else begin
            bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return bad_f3 | misaligned;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        funct3_d     = funct3_q;
        cnt_d        = cnt_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'b0000;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;

        // Outputs are registered, so each one is computed for the state being entered.
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_lo_d = bus.req_addr[1:0];
                    funct3_d  = bus.req_funct3;
                    if (is_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_we) begin
                        state_d  = S_WRITE;
                        mem_we_d = 1'b1;
                        mem_a_d  = bus.req_addr[ADDR_W+1:2];
                        case (bus.req_funct3[1:0])
                            2'b00: begin
                                mem_be_d = 4'b0001 << bus.req_addr[1:0];
                                mem_wd_d = {4{bus.req_wdata[7:0]}};
                            end
                            2'b01: begin
                                mem_be_d = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                                mem_wd_d = {2{bus.req_wdata[15:0]}};
                            end
                            default: begin
                                mem_be_d = 4'b1111;
                                mem_wd_d = bus.req_wdata;
                            end
                        endcase
                    end else begin
                        state_d = S_READ;
                        mem_a_d = bus.req_addr[ADDR_W+1:2];
                        cnt_d   = 2'(READ_LATENCY);
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_READ: begin
                if (cnt_q == 2'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extract(funct3_q, addr_lo_q, bus.mem_rd);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= 2'd0;
            funct3_q     <= 3'd0;
            cnt_q        <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_a_q      <= '0;
            mem_wd_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            funct3_q     <= funct3_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_byteEnable = mem_be_q;
    assign bus.mem_a          = mem_a_q;
    assign bus.mem_wd         = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (read latency 1 and 2), each with a
// behavioural memory, checked against a byte-array reference model.
module tb_lsu_mem_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];

    lsu_mem_ctrl_if #(.ADDR_W(AW)) bus0 ();
    lsu_mem_ctrl_if #(.ADDR_W(AW)) bus1 ();

    lsu_mem_ctrl #(.ADDR_W(AW), .READ_LATENCY(1)) dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
    lsu_mem_ctrl #(.ADDR_W(AW), .READ_LATENCY(2)) dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));

    logic          req_valid [2];
    logic          req_we [2];
    logic [2:0]    req_funct3 [2];
    logic [31:0]   req_addr [2];
    logic [31:0]   req_wdata [2];
    logic [31:0]   mem_rd [2];

    logic          req_ready_o [2];
    logic          resp_valid_o [2];
    logic          resp_err_o [2];
    logic [31:0]   resp_rdata_o [2];
    logic          mem_we_o [2];
    logic [3:0]    be_o [2];
    logic [AW-1:0] mem_a_o [2];
    logic [31:0]   mem_wd_o [2];

    assign bus0.req_valid  = req_valid[0];
    assign bus0.req_we     = req_we[0];
    assign bus0.req_funct3 = req_funct3[0];
    assign bus0.req_addr   = req_addr[0];
    assign bus0.req_wdata  = req_wdata[0];
    assign bus0.mem_rd     = mem_rd[0];
    assign bus1.req_valid  = req_valid[1];
    assign bus1.req_we     = req_we[1];
    assign bus1.req_funct3 = req_funct3[1];
    assign bus1.req_addr   = req_addr[1];
    assign bus1.req_wdata  = req_wdata[1];
    assign bus1.mem_rd     = mem_rd[1];

    assign req_ready_o[0]  = bus0.req_ready;
    assign resp_valid_o[0] = bus0.resp_valid;
    assign resp_err_o[0]   = bus0.resp_err;
    assign resp_rdata_o[0] = bus0.resp_rdata;
    assign mem_we_o[0]     = bus0.mem_we;
    assign be_o[0]         = bus0.mem_byteEnable;
    assign mem_a_o[0]      = bus0.mem_a;
    assign mem_wd_o[0]     = bus0.mem_wd;
    assign req_ready_o[1]  = bus1.req_ready;
    assign resp_valid_o[1] = bus1.resp_valid;
    assign resp_err_o[1]   = bus1.resp_err;
    assign resp_rdata_o[1] = bus1.resp_rdata;
    assign mem_we_o[1]     = bus1.mem_we;
    assign be_o[1]         = bus1.mem_byteEnable;
    assign mem_a_o[1]      = bus1.mem_a;
    assign mem_wd_o[1]     = bus1.mem_wd;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5AC30F96;
    endfunction

    // Behavioural synchronous memories: address sampled at the edge, data
    // valid one (instance 0) or two (instance 1) cycles later.
    logic [31:0] tmem [2][1024];
    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic [31:0] wtmp;
    assign mem_rd[0] = rd1[0];
    assign mem_rd[1] = rd2[1];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd1[d] = 32'd0;
            rd2[d] = 32'd0;
            for (int i = 0; i < 1024; i++) tmem[d][i] = init_word(i);
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                rd1[d] <= tmem[d][mem_a_o[d]];
                rd2[d] <= rd1[d];
                if (mem_we_o[d]) begin
                    wtmp = tmem[d][mem_a_o[d]];
                    for (int l = 0; l < 4; l++)
                        if (be_o[d][l]) wtmp[8*l +: 8] = mem_wd_o[d][8*l +: 8];
                    tmem[d][mem_a_o[d]] <= wtmp;
                end
            end
        end
    end

    // Reference model: plain byte-addressed array covering the 4 KiB window.
    logic [7:0] ref_mem [2][4096];

    function automatic logic model_legal(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr);
        int size;
        size = 1 << f3[1:0];
        if (f3[1:0] == 2'b11) return 1'b0;
        if (we && f3[2]) return 1'b0;
        if (!we && f3 == 3'b110) return 1'b0;
        return (int'(addr[1:0]) % size) == 0;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f3,
                                               input logic [11:0] ba);
        logic [31:0] v;
        int size;
        size = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < size; i++)
            v = v | (32'(ref_mem[d][12'(int'(ba) + i)]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
        return v;
    endfunction

    task automatic model_store(input int d, input logic [2:0] f3, input logic [11:0] ba,
                               input logic [31:0] wdata);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) ref_mem[d][12'(int'(ba) + i)] = wdata[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance d (called at a falling edge) and check it
    // through to the cycle after its response.
    task automatic run_req(input int d, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic hold, input string tag, output logic [31:0] rdata_obs);
        int size, lat_exp, lat_obs, wait_n, we_cnt, be_bad;
        logic legal, err_obs;
        logic [31:0] exp_rdata, exp_wd;
        logic [3:0] exp_be;
        logic [11:0] ba;
        size    = 1 << f3[1:0];
        ba      = addr[11:0];
        legal   = model_legal(we, f3, addr);
        lat_exp = !legal ? 1 : (we ? 2 : d + 3);
        exp_rdata = (legal && !we) ? model_load(d, f3, ba) : 32'd0;
        exp_be = 4'b0000;
        for (int i = 0; i < size; i++) exp_be[(int'(ba[1:0]) + i) % 4] = 1'b1;
        for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wdata[8*(l % size) +: 8];

        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        wait_n = 0;
        while (!req_ready_o[d] && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, " ready_before_accept"}, 32'(req_ready_o[d]), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid[d] = 1'b0;
        if (legal && we) model_store(d, f3, ba, wdata);

        lat_obs = 0; we_cnt = 0; be_bad = 0; err_obs = 1'b0; rdata_obs = 32'd0;
        for (int k = 1; k <= 12 && lat_obs == 0; k++) begin
            @(negedge clk);
            if (mem_we_o[d]) we_cnt++;
            if (k == 1 && legal) chk({tag, " mem_a"}, 32'(mem_a_o[d]), 32'(ba[11:2]));
            if (k == 1 && legal && we) begin
                chk({tag, " byte_enable"}, 32'(be_o[d]), 32'(exp_be));
                chk({tag, " mem_wd"}, mem_wd_o[d], exp_wd);
            end else if (be_o[d] != 4'b0000) begin
                be_bad++;
            end
            chk({tag, " ready_busy"}, 32'(req_ready_o[d]), 32'd0);
            if (resp_valid_o[d]) begin
                lat_obs   = k;
                err_obs   = resp_err_o[d];
                rdata_obs = resp_rdata_o[d];
            end
        end
        chk({tag, " latency"}, 32'(lat_obs), 32'(lat_exp));
        chk({tag, " err"}, 32'(err_obs), 32'(!legal));
        chk({tag, " rdata"}, rdata_obs, exp_rdata);
        chk({tag, " mem_we_cycles"}, 32'(we_cnt), 32'(legal && we));
        chk({tag, " idle_byte_enable"}, 32'(be_bad), 32'd0);
        @(negedge clk);
        chk({tag, " resp_pulse_end"}, 32'(resp_valid_o[d]), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready_o[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        int d;
        logic we;
        logic [2:0] f3;
        logic [31:0] addr;

        for (int k = 0; k < 2; k++) begin
            rst[k]        = 1'b1;
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_funct3[k] = 3'd0;
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            for (int i = 0; i < 1024; i++) begin
                w = init_word(i);
                for (int l = 0; l < 4; l++) ref_mem[k][4*i + l] = w[8*l +: 8];
            end
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset req_ready", 32'(req_ready_o[k]), 32'd1);
            chk("reset resp_valid", 32'(resp_valid_o[k]), 32'd0);
            chk("reset resp_err", 32'(resp_err_o[k]), 32'd0);
            chk("reset resp_rdata", resp_rdata_o[k], 32'd0);
            chk("reset mem_we", 32'(mem_we_o[k]), 32'd0);
            chk("reset byte_enable", 32'(be_o[k]), 32'd0);
            chk("reset mem_a", 32'(mem_a_o[k]), 32'd0);
            chk("reset mem_wd", mem_wd_o[k], 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        run_req(0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, "sw_010", r);
        run_req(0, 1'b1, 3'b000, 32'h013, 32'h000000A5, 1'b0, "sb_013", r);
        run_req(0, 1'b0, 3'b000, 32'h013, 32'd0, 1'b0, "lb_013", r);
        chk("lb_013 const", r, 32'hFFFFFFA5);
        run_req(0, 1'b0, 3'b100, 32'h013, 32'd0, 1'b0, "lbu_013", r);
        chk("lbu_013 const", r, 32'h000000A5);

        run_req(0, 1'b1, 3'b010, 32'h000, 32'h80017F02, 1'b0, "sw_000", r);
        run_req(0, 1'b0, 3'b001, 32'h002, 32'd0, 1'b0, "lh_002", r);
        chk("lh_002 const", r, 32'hFFFF8001);
        run_req(0, 1'b0, 3'b101, 32'h002, 32'd0, 1'b0, "lhu_002", r);
        chk("lhu_002 const", r, 32'h00008001);
        run_req(0, 1'b0, 3'b001, 32'h000, 32'd0, 1'b0, "lh_000", r);
        chk("lh_000 const", r, 32'h00007F02);
        run_req(0, 1'b0, 3'b010, 32'h000, 32'd0, 1'b0, "lw_000", r);
        chk("lw_000 const", r, 32'h80017F02);

        run_req(0, 1'b0, 3'b010, 32'h006, 32'd0, 1'b0, "err_lw_006", r);
        run_req(0, 1'b1, 3'b001, 32'h001, 32'h1234, 1'b0, "err_sh_001", r);
        run_req(0, 1'b0, 3'b011, 32'h000, 32'd0, 1'b0, "err_f3_011", r);
        run_req(0, 1'b1, 3'b100, 32'h020, 32'h55, 1'b0, "err_store_f3_100", r);

        run_req(0, 1'b1, 3'b001, 32'h022, 32'h1234BEEF, 1'b1, "b2b_sh", r);
        run_req(0, 1'b0, 3'b101, 32'h022, 32'd0, 1'b1, "b2b_lhu", r);
        req_valid[0] = 1'b0;
        chk("b2b_lhu const", r, 32'h0000BEEF);

        run_req(1, 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, 1'b1, "rl2_sw", r);
        run_req(1, 1'b0, 3'b010, 32'h040, 32'd0, 1'b1, "rl2_lw", r);
        req_valid[1] = 1'b0;
        chk("rl2_lw const", r, 32'hCAFEF00D);
        run_req(1, 1'b0, 3'b000, 32'h043, 32'd0, 1'b0, "rl2_lb", r);
        chk("rl2_lb const", r, 32'hFFFFFFCA);

        // Reset arriving in the middle of a store's write cycle.
        req_valid[0]  = 1'b1;
        req_we[0]     = 1'b1;
        req_funct3[0] = 3'b010;
        req_addr[0]   = 32'h080;
        req_wdata[0]  = 32'h0BADF00D;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        #2;
        chk("rst_mid mem_we_before", 32'(mem_we_o[0]), 32'd1);
        rst[0] = 1'b1;
        #1;
        chk("rst_mid mem_we_async", 32'(mem_we_o[0]), 32'd0);
        chk("rst_mid ready", 32'(req_ready_o[0]), 32'd1);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid no_resp", 32'(resp_valid_o[0]), 32'd0);
            chk("rst_mid ready_after", 32'(req_ready_o[0]), 32'd1);
        end
        run_req(0, 1'b0, 3'b010, 32'h080, 32'd0, 1'b0, "rst_mid lw_080", r);

        for (int n = 0; n < 200; n++) begin
            d    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            run_req(d, we, f3, addr, $urandom(), ($urandom_range(0, 3) == 0),
                    $sformatf("rand%0d", n), r);
            req_valid[d] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
